// File: rtl/sd_irq_source_if.sv
// CIA-style E-clock peripheral bus as seen by the SD interrupt source.
interface sd_irq_source_if;
  logic       r_w;
  logic       _cs;
  logic       e;
  logic [3:0] rs;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output r_w, _cs, e, rs, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  r_w, _cs, e, rs, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/sd_irq_source.sv
// SD interrupt source: latches card-detect/xfer-done/error events, clear-on-read status, drives _int2.
// Define SD_IRQ_MASK_EN to add a writable interrupt mask register at MASK_RS.
module sd_irq_source #(
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter logic [3:0]  STATUS_RS       = 4'hE,
  parameter logic [3:0]  MASK_RS         = 4'hF
) (
  input  logic           clk,
  input  logic           _reset,
  sd_irq_source_if.slave bus,
  input  logic           irq_enable,
  input  logic           cd_n,
  input  logic           ev_xfer_done,
  input  logic           ev_error,
  output logic           _int2
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      e_sync_q;
  logic            e_prev_q;
  logic [1:0]      cd_sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            card_present_q, card_present_d;
  logic [2:0]      pending_q, pending_d;
  logic [7:0]      snapshot_q, snapshot_d;
  logic            int2_q, int2_d;
  logic [2:0]      mask;

  logic       e_rise, e_fall;
  logic       status_rd;
  logic       cd_stable, cd_toggle;
  logic [2:0] clr, set;
  logic [7:0] status;

  assign e_rise    = e_sync_q[1] & ~e_prev_q;
  assign e_fall    = ~e_sync_q[1] & e_prev_q;
  assign status_rd = ~bus._cs & bus.r_w & (bus.rs == STATUS_RS);
  assign status    = {card_present_q, 4'b0000, pending_q};

`ifdef SD_IRQ_MASK_EN
  logic [2:0] mask_q, mask_d;
  logic       mask_rd, mask_wr;

  assign mask_rd = ~bus._cs & bus.r_w & (bus.rs == MASK_RS);
  assign mask_wr = ~bus._cs & ~bus.r_w & (bus.rs == MASK_RS);
  assign mask    = mask_q;
  assign mask_d  = (e_fall && mask_wr) ? bus.data_in[2:0] : mask_q;
  assign bus.data_oe = bus.e & (status_rd | mask_rd);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) mask_q <= 3'b111;
    else         mask_q <= mask_d;
  end

  logic [4:0] unused_data_in;
  assign unused_data_in = bus.data_in[7:3];
`else
  assign mask        = 3'b111;
  assign bus.data_oe = bus.e & status_rd;

  logic [11:0] unused_bus;
  assign unused_bus = {bus.data_in, MASK_RS};
`endif

  // Card detect debounce: count only while the synced pin disagrees with card_present.
  always_comb begin
    cd_stable      = (cd_sync_q[1] == ~card_present_q);
    cd_toggle      = ~cd_stable && (cnt_q == CntMax);
    cnt_d          = (cd_stable || cd_toggle) ? '0 : cnt_q + CntW'(1);
    card_present_d = card_present_q ^ cd_toggle;
  end

  // Clear only what the reader saw; a same-cycle event wins over the clear.
  always_comb begin
    snapshot_d = snapshot_q;
    if (e_rise && status_rd) snapshot_d = status;
`ifdef SD_IRQ_MASK_EN
    if (e_rise && mask_rd) snapshot_d = {5'b00000, mask_q};
`endif
    clr       = (e_fall && status_rd) ? snapshot_q[2:0] : 3'b000;
    set       = {ev_error, ev_xfer_done, cd_toggle};
    pending_d = (pending_q & ~clr) | set;
    int2_d    = ~(irq_enable & |(pending_q & mask));
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      e_sync_q       <= 2'b00;
      e_prev_q       <= 1'b0;
      cd_sync_q      <= 2'b11;
      cnt_q          <= '0;
      card_present_q <= 1'b0;
      pending_q      <= 3'b000;
      snapshot_q     <= 8'h00;
      int2_q         <= 1'b1;
    end else begin
      e_sync_q       <= {e_sync_q[0], bus.e};
      e_prev_q       <= e_sync_q[1];
      cd_sync_q      <= {cd_sync_q[0], cd_n};
      cnt_q          <= cnt_d;
      card_present_q <= card_present_d;
      pending_q      <= pending_d;
      snapshot_q     <= snapshot_d;
      int2_q         <= int2_d;
    end
  end

  assign bus.data_out = snapshot_q;
  assign _int2        = int2_q;

endmodule
